// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM states, op encoding, default widths.
package mem_arb_pkg;

   localparam int DEF_ADDR_W  = 6;
   localparam int DEF_BLOCK_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } arb_state_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } arb_op_t;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping modulo N_PORTS.
module rr_grant #(
   parameter int N_PORTS = 2,
   parameter int PTR_W   = 1
)(
   input  logic [N_PORTS-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [PTR_W-1:0]   grant,
   output logic               any
);

   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= N_PORTS) sum = sum - N_PORTS;
      return PTR_W'(sum);
   endfunction

   // scan from farthest to nearest so the nearest requester after ptr wins
   always_comb begin
      grant = '0;
      any   = |req;
      for (int off = N_PORTS - 1; off >= 0; off--) begin
         if (req[wrap_add(ptr, off)]) grant = wrap_add(ptr, off);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises block transfers from N cache controllers onto one busywait memory port,
// round-robin fair, returning read data and busywait to the granted requester.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N_PORTS = 2,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int BLOCK_W = DEF_BLOCK_W
)(
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic [N_PORTS-1:0]         REQ_READ,
   input  logic [N_PORTS-1:0]         REQ_WRITE,
   input  logic [N_PORTS*ADDR_W-1:0]  REQ_ADDRESS,
   input  logic [N_PORTS*BLOCK_W-1:0] REQ_WRITEDATA,
   output logic [BLOCK_W-1:0]         REQ_READDATA,
   output logic [N_PORTS-1:0]         REQ_BUSYWAIT,
   output logic                       MEM_READ,
   output logic                       MEM_WRITE,
   output logic [ADDR_W-1:0]          MEM_ADDRESS,
   output logic [BLOCK_W-1:0]         MEM_WRITEDATA,
   input  logic [BLOCK_W-1:0]         MEM_READDATA,
   input  logic                       MEM_BUSYWAIT
);

   localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   arb_state_t         state, state_next;
   arb_op_t            op;
   logic [PTR_W-1:0]   ptr, grant, sel;
   logic               any_req, first_cycle, mem_done;
   logic [N_PORTS-1:0] requesting;
   logic [ADDR_W-1:0]  addr_q;
   logic [BLOCK_W-1:0] wdata_q, rdata_q;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] g);
      if (int'(g) == N_PORTS - 1) return '0;
      return g + 1'b1;
   endfunction

   // a simultaneous read+write counts as a write, but both mark the port as requesting
   assign requesting = REQ_READ | REQ_WRITE;

   rr_grant #(.N_PORTS(N_PORTS), .PTR_W(PTR_W)) u_rr_grant (
      .req   (requesting),
      .ptr   (ptr),
      .grant (sel),
      .any   (any_req)
   );

   // memory busywait is not trusted in the first ISSUE cycle (memory has not seen the strobe yet)
   assign mem_done = (state == ISSUE) && !first_cycle && !MEM_BUSYWAIT;

   assign MEM_ADDRESS   = addr_q;
   assign MEM_WRITEDATA = wdata_q;
   assign REQ_READDATA  = rdata_q;

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RESET) state <= IDLE;
      else       state <= state_next;
   end

   // next-state and memory strobes
   always_comb begin
      state_next = state;
      MEM_READ   = 1'b0;
      MEM_WRITE  = 1'b0;
      case (state)
         IDLE:    if (any_req) state_next = ISSUE;
         ISSUE: begin
            MEM_READ  = (op == OP_READ);
            MEM_WRITE = (op == OP_WRITE);
            if (mem_done) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // latch the winning request, capture read data on completion, advance ptr after DONE
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ptr         <= '0;
         grant       <= '0;
         op          <= OP_READ;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         first_cycle <= 1'b0;
      end else begin
         first_cycle <= 1'b0;
         if (state == IDLE && any_req) begin
            grant       <= sel;
            op          <= REQ_WRITE[sel] ? OP_WRITE : OP_READ;
            addr_q      <= REQ_ADDRESS[int'(sel)*ADDR_W +: ADDR_W];
            wdata_q     <= REQ_WRITEDATA[int'(sel)*BLOCK_W +: BLOCK_W];
            first_cycle <= 1'b1;
         end
         // completes even if the requester withdrew; the data is simply not consumed
         if (mem_done && op == OP_READ) rdata_q <= MEM_READDATA;
         if (state == DONE) ptr <= next_ptr(grant);
      end
   end

   // every requester stalls except the granted one during its DONE cycle
   always_comb begin
      REQ_BUSYWAIT = requesting;
      for (int i = 0; i < N_PORTS; i++) begin
         if (state == DONE && int'(grant) == i) REQ_BUSYWAIT[i] = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a 2-port instance with a busywait memory and a 4-port instance.
module tb_mem_port_arbiter;

   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   // 2-port instance
   logic [1:0]  a_rd, a_wr, a_bw;
   logic [11:0] a_addr;
   logic [63:0] a_wdata;
   logic [31:0] a_rdata, a_mwdata, a_mrdata;
   logic        a_mrd, a_mwr, a_mbusy;
   logic [5:0]  a_maddr;

   // 4-port instance
   logic [3:0]   b_rd, b_wr, b_bw;
   logic [23:0]  b_addr;
   logic [127:0] b_wdata;
   logic [31:0]  b_rdata, b_mwdata, b_mrdata;
   logic         b_mrd, b_mwr, b_mbusy;
   logic [5:0]   b_maddr;

   mem_port_arbiter #(.N_PORTS(2), .ADDR_W(6), .BLOCK_W(32)) dut_a (
      .CLK(CLK), .RESET(RESET),
      .REQ_READ(a_rd), .REQ_WRITE(a_wr), .REQ_ADDRESS(a_addr), .REQ_WRITEDATA(a_wdata),
      .REQ_READDATA(a_rdata), .REQ_BUSYWAIT(a_bw),
      .MEM_READ(a_mrd), .MEM_WRITE(a_mwr), .MEM_ADDRESS(a_maddr), .MEM_WRITEDATA(a_mwdata),
      .MEM_READDATA(a_mrdata), .MEM_BUSYWAIT(a_mbusy)
   );

   mem_port_arbiter #(.N_PORTS(4), .ADDR_W(6), .BLOCK_W(32)) dut_b (
      .CLK(CLK), .RESET(RESET),
      .REQ_READ(b_rd), .REQ_WRITE(b_wr), .REQ_ADDRESS(b_addr), .REQ_WRITEDATA(b_wdata),
      .REQ_READDATA(b_rdata), .REQ_BUSYWAIT(b_bw),
      .MEM_READ(b_mrd), .MEM_WRITE(b_mwr), .MEM_ADDRESS(b_maddr), .MEM_WRITEDATA(b_mwdata),
      .MEM_READDATA(b_mrdata), .MEM_BUSYWAIT(b_mbusy)
   );

   // memory for instance A: read ROM, busy for busy_lat strobe cycles, write capture
   logic [31:0] rom [64];
   int          busy_lat;
   int          issue_cnt;
   int          wr_count;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;

   always @(posedge CLK) begin
      if (RESET) issue_cnt <= 0;
      else if (a_mrd || a_mwr) issue_cnt <= issue_cnt + 1;
      else issue_cnt <= 0;
      if (a_mwr && !a_mbusy) begin
         wr_count <= wr_count + 1;
         wr_addr  <= a_maddr;
         wr_data  <= a_mwdata;
      end
   end
   assign a_mbusy  = (a_mrd || a_mwr) && (issue_cnt < busy_lat);
   assign a_mrdata = rom[a_maddr];

   assign b_mbusy  = 1'b0;
   assign b_mrdata = 32'h0;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   // advance until port's busywait drops (bounded); cyc stays -1 on timeout
   task automatic wait_low_a(input int port, output int cyc, output int nrd, output int nwr);
      cyc = -1; nrd = 0; nwr = 0;
      for (int c = 1; c <= 30; c++) begin
         step();
         if (a_mrd) nrd++;
         if (a_mwr) nwr++;
         if (!a_bw[port]) begin
            cyc = c;
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc, nrd, nwr, fell, wrc0, ng, g;
      int grants [5];

      for (int i = 0; i < 64; i++) rom[i] = 32'hA500_0000 | 32'(i);
      rom[5] = 32'hDEAD_BEEF;
      rom[7] = 32'hCAFE_F00D;
      wr_count = 0;
      busy_lat = 5;
      RESET = 1'b1;
      a_rd = '0; a_wr = '0; a_addr = '0; a_wdata = '0;
      b_rd = '0; b_wr = '0; b_addr = '0; b_wdata = '0;

      // reset state
      step(); step();
      check("rst_mem_read",  64'(a_mrd),    64'(0));
      check("rst_mem_write", 64'(a_mwr),    64'(0));
      check("rst_mem_addr",  64'(a_maddr),  64'(0));
      check("rst_mem_wdata", 64'(a_mwdata), 64'(0));
      check("rst_readdata",  64'(a_rdata),  64'(0));
      check("rst_busywait",  64'(a_bw),     64'(0));
      RESET = 1'b0;

      // lone read, 5 busy cycles
      a_rd = 2'b01; a_addr[5:0] = 6'h05;
      #1;
      check("t1_bw_same_cycle", 64'(a_bw), 64'(2'b01));
      wait_low_a(0, cyc, nrd, nwr);
      check("t1_done_cycle",  64'(cyc),     64'(7));
      check("t1_read_cycles", 64'(nrd),     64'(6));
      check("t1_no_write",    64'(nwr),     64'(0));
      check("t1_readdata",    64'(a_rdata), 64'(32'hDEAD_BEEF));
      check("t1_addr",        64'(a_maddr), 64'(6'h05));
      check("t1_strobe_done", 64'(a_mrd),   64'(0));
      step();
      check("t1_bw_high_again", 64'(a_bw[0]), 64'(1));
      check("t1_idle_strobe",   64'(a_mrd),   64'(0));
      a_rd = 2'b00;
      step();
      check("t1_no_new_txn", 64'(a_mrd), 64'(0));

      // simultaneous pair after reset, twice
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      busy_lat = 1;
      a_rd = 2'b11; a_addr = {6'h02, 6'h01};
      wait_low_a(0, cyc, nrd, nwr);
      check("t2_p0_first",    64'(cyc),     64'(3));
      check("t2_p0_reads",    64'(nrd),     64'(2));
      check("t2_p1_stalled",  64'(a_bw[1]), 64'(1));
      check("t2_p0_data",     64'(a_rdata), 64'(32'hA500_0001));
      a_rd = 2'b10;
      step();
      check("t2_gap_idle",    64'(a_mrd),   64'(0));
      check("t2_p1_still",    64'(a_bw[1]), 64'(1));
      wait_low_a(1, cyc, nrd, nwr);
      check("t2_p1_done",     64'(cyc),     64'(3));
      check("t2_p1_data",     64'(a_rdata), 64'(32'hA500_0002));
      a_rd = 2'b11;
      wait_low_a(0, cyc, nrd, nwr);
      check("t2_wrap_p0",     64'(cyc),     64'(4));
      check("t2_wrap_p1_bw",  64'(a_bw[1]), 64'(1));
      a_rd = 2'b10;
      wait_low_a(1, cyc, nrd, nwr);
      check("t2_wrap_p1",     64'(cyc),     64'(4));
      a_rd = 2'b00;

      // read+write together is a write
      busy_lat = 2;
      wrc0 = wr_count;
      a_rd = 2'b10; a_wr = 2'b10; a_addr[11:6] = 6'h3F; a_wdata[63:32] = 32'h1234_5678;
      wait_low_a(1, cyc, nrd, nwr);
      check("t4_done",      64'(cyc),      64'(5));
      check("t4_write_cyc", 64'(nwr),      64'(3));
      check("t4_no_read",   64'(nrd),      64'(0));
      check("t4_wr_once",   64'(wr_count), 64'(wrc0 + 1));
      check("t4_wr_addr",   64'(wr_addr),  64'(6'h3F));
      check("t4_wr_data",   64'(wr_data),  64'(32'h1234_5678));
      check("t4_rd_hold",   64'(a_rdata),  64'(32'hA500_0002));
      a_rd = 2'b00; a_wr = 2'b00;

      // requester withdraws mid-ISSUE
      busy_lat = 3;
      a_rd = 2'b01; a_addr[5:0] = 6'h07;
      step(); step();
      check("t6_issue_strobe", 64'(a_mrd), 64'(1));
      step();
      a_rd = 2'b00;
      #1;
      check("t6_bw_dropped", 64'(a_bw), 64'(0));
      fell = -1;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (!a_mrd) begin
            fell = c;
            break;
         end
      end
      check("t6_access_completes", 64'(fell),    64'(3));
      check("t6_readdata",         64'(a_rdata), 64'(32'hCAFE_F00D));
      busy_lat = 1;
      a_rd = 2'b11; a_addr = {6'h02, 6'h01};
      wait_low_a(1, cyc, nrd, nwr);
      check("t6_ptr_p1_first", 64'(cyc),     64'(4));
      check("t6_p0_waits",     64'(a_bw[0]), 64'(1));
      check("t6_p1_data",      64'(a_rdata), 64'(32'hA500_0002));
      a_rd = 2'b01;
      wait_low_a(0, cyc, nrd, nwr);
      check("t6_p0_next",      64'(cyc),     64'(4));
      check("t6_p0_data",      64'(a_rdata), 64'(32'hA500_0001));
      a_rd = 2'b00;

      // reset during the third ISSUE cycle of a write
      busy_lat = 5;
      wrc0 = wr_count;
      a_wr = 2'b01; a_addr[5:0] = 6'h0A; a_wdata[31:0] = 32'hAAAA_5555;
      step(); step(); step(); step();
      check("t5_issue3_strobe", 64'(a_mwr), 64'(1));
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      check("t5_rst_write", 64'(a_mwr),    64'(0));
      check("t5_rst_read",  64'(a_mrd),    64'(0));
      check("t5_rst_addr",  64'(a_maddr),  64'(0));
      check("t5_rst_wdata", 64'(a_mwdata), 64'(0));
      check("t5_abandoned", 64'(wr_count), 64'(wrc0));
      busy_lat = 1;
      a_rd = 2'b10;
      wait_low_a(0, cyc, nrd, nwr);
      check("t5_ptr0_restart", 64'(cyc),      64'(3));
      check("t5_wr_once",      64'(wr_count), 64'(wrc0 + 1));
      check("t5_wr_addr",      64'(wr_addr),  64'(6'h0A));
      check("t5_wr_data",      64'(wr_data),  64'(32'hAAAA_5555));
      a_wr = 2'b00;
      wait_low_a(1, cyc, nrd, nwr);
      check("t5_p1_after",     64'(cyc),      64'(4));
      check("t5_p1_data",      64'(a_rdata),  64'(32'hA500_0002));
      a_rd = 2'b00;

      // four ports requesting continuously
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      b_rd = 4'hF;
      b_addr = {6'd11, 6'd10, 6'd9, 6'd8};
      ng = 0;
      for (int c = 1; c <= 40; c++) begin
         step();
         if (b_bw != 4'hF) begin
            g = 0;
            for (int j = 0; j < 4; j++) if (!b_bw[j]) g = j;
            check("t3_one_low", 64'($countones(~b_bw)), 64'(1));
            check("t3_addr",    64'(b_maddr),           64'(8 + g));
            grants[ng] = g;
            ng++;
            if (ng == 5) break;
         end
      end
      check("t3_count", 64'(ng), 64'(5));
      for (int k = 0; k < 5; k++) check("t3_grant_order", 64'(grants[k]), 64'(k % 4));
      b_rd = 4'h0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
